// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle-factor fetch controller: walks every NTT stage, reads twiddle pairs from a dual-port ROM
// and hands them to a butterfly consumer over a valid/ready link. Optional tags: TW_STAGE_TAG_EN.
module twiddle_fetch_ctrl #(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned LENGTH = 1024,
    parameter int unsigned LOGN   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      inv,
    output logic                      rom_en,
    output logic [$clog2(LENGTH)-1:0] rom_addra,
    output logic [$clog2(LENGTH)-1:0] rom_addrb,
    input  logic [WIDTH-1:0]          rom_doa,
    input  logic [WIDTH-1:0]          rom_dob,
    output logic [WIDTH-1:0]          tw_a,
    output logic [WIDTH-1:0]          tw_b,
    output logic                      tw_valid,
    input  logic                      tw_ready,
    output logic                      busy,
    output logic                      done
`ifdef TW_STAGE_TAG_EN
    ,
    output logic [$clog2(LOGN)-1:0]   tw_stage,
    output logic                      tw_last
`endif
);

    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned SW = $clog2(LOGN);
    localparam int unsigned N  = 1 << LOGN;
    localparam int unsigned JW = LOGN;

    localparam logic [JW-1:0] JLast     = JW'(N / 2 - 2);
    localparam logic [SW-1:0] StageLast = SW'(LOGN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t        state;
    logic [JW-1:0] j;
    logic [SW-1:0] stage;
    logic          inv_lat;

    logic          issue;
    logic          last_j;
    logic          last_stage;
    logic [SW-1:0] shamt;
    logic [AW-1:0] base;
    logic [AW-1:0] step;

    // A new pair may enter the output register only when it is empty or being drained.
    assign issue      = (state == StRun) && (!tw_valid || tw_ready);
    assign rom_en     = issue;
    assign last_j     = (j == JLast);
    assign last_stage = inv_lat ? (stage == '0) : (stage == StageLast);
    assign busy       = (state != StIdle);
    assign done       = (state == StDone);
    assign tw_a       = rom_doa;
    assign tw_b       = rom_dob;

    always_comb begin
        shamt     = StageLast - stage;
        base      = inv_lat ? AW'(N) : '0;
        step      = AW'(1) << stage;
        rom_addra = '0;
        rom_addrb = '0;
        if (state != StIdle) begin
            rom_addra = base + step + (AW'(j) >> shamt);
            // j is always even, so j+1 is j with bit 0 set.
            rom_addrb = base + step + ((AW'(j) | AW'(1)) >> shamt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            j        <= '0;
            stage    <= '0;
            inv_lat  <= 1'b0;
            tw_valid <= 1'b0;
        end else begin
            if (issue) begin
                tw_valid <= 1'b1;
            end else if (tw_ready) begin
                tw_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StRun;
                        inv_lat <= inv;
                        j       <= '0;
                        stage   <= inv ? StageLast : '0;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (last_j) begin
                            j <= '0;
                            if (last_stage) begin
                                state <= StDrain;
                            end else if (inv_lat) begin
                                stage <= stage - SW'(1);
                            end else begin
                                stage <= stage + SW'(1);
                            end
                        end else begin
                            j <= j + JW'(2);
                        end
                    end
                end
                StDrain: begin
                    if (tw_valid && tw_ready) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef TW_STAGE_TAG_EN
    // Tags travel with the pair: captured on issue, alongside the ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_stage <= '0;
            tw_last  <= 1'b0;
        end else if (issue) begin
            tw_stage <= stage;
            tw_last  <= last_j;
        end
    end
`endif

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Self-checking bench for twiddle_fetch_ctrl: table of transform runs checked against a
// stage/butterfly reference model, plus directed address and reset sequences.
module tb_twiddle_fetch_ctrl;

    localparam int WIDTH  = 96;
    localparam int LENGTH = 1024;
    localparam int LOGN   = 8;
    localparam int N      = 256;
    localparam int AW     = 10;
    localparam int LIMIT  = 6000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             inv;
    logic             rom_en;
    logic [AW-1:0]    rom_addra;
    logic [AW-1:0]    rom_addrb;
    logic [WIDTH-1:0] rom_doa;
    logic [WIDTH-1:0] rom_dob;
    logic [WIDTH-1:0] tw_a;
    logic [WIDTH-1:0] tw_b;
    logic             tw_valid;
    logic             tw_ready;
    logic             busy;
    logic             done;
`ifdef TW_STAGE_TAG_EN
    logic [2:0]       tw_stage;
    logic             tw_last;
`endif

    twiddle_fetch_ctrl #(
        .WIDTH (WIDTH),
        .LENGTH(LENGTH),
        .LOGN  (LOGN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inv      (inv),
        .rom_en   (rom_en),
        .rom_addra(rom_addra),
        .rom_addrb(rom_addrb),
        .rom_doa  (rom_doa),
        .rom_dob  (rom_dob),
        .tw_a     (tw_a),
        .tw_b     (tw_b),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .busy     (busy),
        .done     (done)
`ifdef TW_STAGE_TAG_EN
        ,
        .tw_stage (tw_stage),
        .tw_last  (tw_last)
`endif
    );

    typedef struct {
        bit inv;
        int stall_pct;
        int abort_at;
        int poke_at;
        int exp_pairs;
        int exp_first_a;
        int exp_first_b;
        int exp_last_a;
        int exp_last_b;
    } vec_t;

    logic [WIDTH-1:0] rom [LENGTH];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               exp_a[$];
    int               exp_b[$];
    int               exp_s[$];
    bit               exp_l[$];
    logic [WIDTH-1:0] got_a[$];
    logic [WIDTH-1:0] got_b[$];
    int r_t0, r_first, r_last, r_done, r_bf, r_bl, r_iss, r_ndone, r_nlast;
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port ROM with one registered cycle of latency, holding while disabled.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_doa <= rom[rom_addra];
            rom_dob <= rom[rom_addrb];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_en"}, rom_en, 0);
        check({tag, "_addra"}, rom_addra, 0);
        check({tag, "_addrb"}, rom_addrb, 0);
        check({tag, "_tw_valid"}, tw_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef TW_STAGE_TAG_EN
        check({tag, "_tw_stage"}, tw_stage, 0);
        check({tag, "_tw_last"}, tw_last, 0);
`endif
    endtask

    // Reference order: stage by stage, butterflies j = 0,2,..,N/2-2, twiddle index 2^s + j/2^(LOGN-1-s).
    function automatic void build_expected(input bit v);
        int s;
        exp_a.delete();
        exp_b.delete();
        exp_s.delete();
        exp_l.delete();
        for (int p = 0; p < LOGN; p++) begin
            s = v ? (LOGN - 1 - p) : p;
            for (int jj = 0; jj < N / 2; jj += 2) begin
                exp_a.push_back((v ? N : 0) + (2 ** s) + jj / (2 ** (LOGN - 1 - s)));
                exp_b.push_back((v ? N : 0) + (2 ** s) + (jj + 1) / (2 ** (LOGN - 1 - s)));
                exp_s.push_back(s);
                exp_l.push_back(jj == N / 2 - 2);
            end
        end
    endfunction

    function automatic logic draw_ready(input int pct);
        return ($urandom_range(99) >= pct);
    endfunction

    task automatic run_xfer(input vec_t v);
        int               k = 0;
        bit               fin = 0;
        bit               poked = 0;
        bit               stalled_prev = 0;
        logic [WIDTH-1:0] hold_a = '0;
        logic [WIDTH-1:0] hold_b = '0;
        build_expected(v.inv);
        got_a.delete();
        got_b.delete();
        r_first = -1; r_last = -1; r_done = -1; r_bf = -1; r_bl = -1;
        r_iss = 0; r_ndone = 0; r_nlast = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        inv      = v.inv;
        tw_ready = draw_ready(v.stall_pct);
        r_t0     = cyc;
        for (int c = 0; c < LIMIT && !fin; c++) begin
            @(negedge clk);
            if (r_done >= 0 && cyc == r_done + 1) begin
                check("idle_after_done", busy, 0);
                fin = 1;
            end
            if (busy) begin
                if (r_bf < 0) r_bf = cyc;
                r_bl = cyc;
            end
            if (rom_en) r_iss++;
            if (tw_valid) begin
                if (r_first < 0) r_first = cyc;
                r_last = cyc;
            end
            if (stalled_prev) begin
                check("stall_keep_valid", tw_valid, 1);
                check("stall_hold_a", tw_a, hold_a);
                check("stall_hold_b", tw_b, hold_b);
            end
            stalled_prev = tw_valid && !tw_ready;
            if (stalled_prev) begin
                check("stall_rom_en", rom_en, 0);
                hold_a = tw_a;
                hold_b = tw_b;
            end
            if (tw_valid && tw_ready) begin
                if (k < exp_a.size()) begin
                    check("pair_a", tw_a, rom[exp_a[k]]);
                    check("pair_b", tw_b, rom[exp_b[k]]);
`ifdef TW_STAGE_TAG_EN
                    check("tw_stage", tw_stage, exp_s[k]);
                    check("tw_last", tw_last, exp_l[k]);
                    if (tw_last) r_nlast++;
`endif
                end else begin
                    check("extra_pair", k, exp_a.size() - 1);
                end
                got_a.push_back(tw_a);
                got_b.push_back(tw_b);
                k++;
            end
            if (done) begin
                r_ndone++;
                r_done = cyc;
            end
            if (!fin && v.abort_at >= 0 && k == v.abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                @(negedge clk);
                check_reset_outputs("abort_hold");
                rst = 1'b0;
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                if (v.poke_at >= 0 && k >= v.poke_at && !poked) begin
                    start = 1'b1;
                    poked = 1;
                end
                inv      = 1'($urandom);
                tw_ready = draw_ready(v.stall_pct);
            end
        end
        start = 1'b0;
        check("run_finished", fin, 1);
        check("pairs", k, v.exp_pairs);
        if (got_a.size() > 0) begin
            check("first_a", got_a[0], rom[v.exp_first_a]);
            check("first_b", got_b[0], rom[v.exp_first_b]);
            check("last_a", got_a[got_a.size() - 1], rom[v.exp_last_a]);
            check("last_b", got_b[got_b.size() - 1], rom[v.exp_last_b]);
        end
        if (v.abort_at < 0) begin
            check("issues", r_iss, v.exp_pairs);
            check("done_pulses", r_ndone, 1);
`ifdef TW_STAGE_TAG_EN
            check("tw_last_count", r_nlast, LOGN);
`endif
            if (v.stall_pct == 0) begin
                check("t_first_valid", r_first, r_t0 + 2);
                check("t_last_valid", r_last, r_t0 + 513);
                check("t_done", r_done, r_t0 + 514);
                check("t_busy_first", r_bf, r_t0 + 1);
                check("t_busy_last", r_bl, r_t0 + 514);
            end
        end else begin
            check("abort_done_pulses", r_ndone, 0);
        end
    endtask

    initial begin
        for (int a = 0; a < LENGTH; a++) begin
            rom[a] = {16'(a), 16'hBEEF, $urandom, $urandom};
        end
        //          inv   stall abort poke pairs fa   fb   la   lb
        vecs[0] = '{1'b0, 0,   -1,   -1,  512,  1,   1,   254, 255};
        vecs[1] = '{1'b1, 0,   -1,   -1,  512,  384, 385, 257, 257};
        vecs[2] = '{1'b0, 50,  -1,   -1,  512,  1,   1,   254, 255};
        vecs[3] = '{1'b1, 50,  -1,   -1,  512,  384, 385, 257, 257};
        vecs[4] = '{1'b0, 0,   100,  -1,  100,  1,   1,   3,   3};
        vecs[5] = '{1'b0, 0,   -1,   -1,  512,  1,   1,   254, 255};
        vecs[6] = '{1'b0, 0,   -1,   200, 512,  1,   1,   254, 255};
        vecs[7] = '{1'b1, 70,  -1,   50,  512,  384, 385, 257, 257};

        rst      = 1'b1;
        start    = 1'b0;
        inv      = 1'b0;
        tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i]);
            if (i == 0) begin
                // Stage 3, j=16 is pair 3*64+8; stage 7 starts at pair 448.
                check("s3_j16_a", got_a[200], rom[9]);
                check("s3_j16_b", got_b[200], rom[9]);
                check("s7_first_a", got_a[448], rom[128]);
                check("s7_first_b", got_b[448], rom[129]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
